// File: rtl/lsu_mem_initiator.sv
// Load/store unit, initiator side of the data-memory bus: one access in flight.
// Optional LSU_BUS_TIMEOUT_EN forces an access fault after TIMEOUT_CYCLES in REQ/RSP.
module lsu_mem_initiator #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_funct3_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_done_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_err_o,
    output logic [1:0]  lsu_err_cause_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_ERR} state_t;

    state_t      r_state;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [1:0]  r_cause;

    logic        w_illegal;
    logic        w_misal;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shift;
    logic [31:0] w_load;
    logic        w_tmo;

    assign lsu_ready_o = (r_state == S_IDLE);

    always_comb begin
        if (lsu_we_i)
            w_illegal = lsu_funct3_i[2] || (lsu_funct3_i[1:0] == 2'b11);
        else
            w_illegal = (lsu_funct3_i == 3'b011) || (lsu_funct3_i == 3'b110) ||
                        (lsu_funct3_i == 3'b111);
        w_misal = ((lsu_funct3_i[1:0] == 2'b01) && lsu_addr_i[0]) ||
                  ((lsu_funct3_i[1:0] == 2'b10) && (lsu_addr_i[1:0] != 2'b00));
        case (lsu_funct3_i[1:0])
            2'b00: begin
                w_be    = 4'b0001 << lsu_addr_i[1:0];
                w_wdata = {4{lsu_wdata_i[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << lsu_addr_i[1:0];
                w_wdata = {2{lsu_wdata_i[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = lsu_wdata_i;
            end
        endcase
    end

    // Right-justify the addressed lane, then extend by funct3
    always_comb begin
        w_shift = mem_rdata_i >> {r_off, 3'b000};
        case (r_funct3)
            3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b010:  w_load = mem_rdata_i;
            3'b100:  w_load = {24'd0, w_shift[7:0]};
            3'b101:  w_load = {16'd0, w_shift[15:0]};
            default: w_load = 32'd0;
        endcase
    end

`ifdef LSU_BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;

    assign w_tmo = (r_state == S_REQ || r_state == S_RSP) &&
                   (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_cnt <= '0;
        else if (r_state == S_REQ && !mem_gnt_i)
            r_cnt <= r_cnt + 1'b1;
        else if (r_state == S_RSP && !mem_rvalid_i)
            r_cnt <= r_cnt + 1'b1;
        else
            r_cnt <= '0;
    end
`else
    // No watchdog: the unit waits on the bus indefinitely
    assign w_tmo = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state         <= S_IDLE;
            r_we            <= 1'b0;
            r_funct3        <= 3'd0;
            r_off           <= 2'd0;
            r_cause         <= 2'd0;
            lsu_done_o      <= 1'b0;
            lsu_rdata_o     <= 32'd0;
            lsu_err_o       <= 1'b0;
            lsu_err_cause_o <= 2'd0;
            mem_req_o       <= 1'b0;
            mem_we_o        <= 1'b0;
            mem_be_o        <= 4'd0;
            mem_addr_o      <= 32'd0;
            mem_wdata_o     <= 32'd0;
        end else begin
            lsu_done_o      <= 1'b0;
            lsu_rdata_o     <= 32'd0;
            lsu_err_o       <= 1'b0;
            lsu_err_cause_o <= 2'd0;
            unique case (r_state)
                S_IDLE: begin
                    if (lsu_valid_i) begin
                        r_we     <= lsu_we_i;
                        r_funct3 <= lsu_funct3_i;
                        r_off    <= lsu_addr_i[1:0];
                        if (w_illegal) begin
                            r_state <= S_ERR;
                            r_cause <= 2'd3;
                        end else if (w_misal) begin
                            r_state <= S_ERR;
                            r_cause <= {1'b0, lsu_we_i};
                        end else begin
                            r_state     <= S_REQ;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= lsu_we_i;
                            mem_be_o    <= w_be;
                            mem_addr_o  <= {lsu_addr_i[31:2], 2'b00};
                            mem_wdata_o <= lsu_we_i ? w_wdata : 32'd0;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt_i || w_tmo) begin
                        r_state     <= mem_gnt_i ? S_RSP : S_IDLE;
                        mem_req_o   <= 1'b0;
                        mem_we_o    <= 1'b0;
                        mem_be_o    <= 4'd0;
                        mem_addr_o  <= 32'd0;
                        mem_wdata_o <= 32'd0;
                    end
                    if (!mem_gnt_i && w_tmo) begin
                        lsu_done_o      <= 1'b1;
                        lsu_err_o       <= 1'b1;
                        lsu_err_cause_o <= 2'd2;
                    end
                end
                S_RSP: begin
                    if (mem_rvalid_i) begin
                        r_state    <= S_IDLE;
                        lsu_done_o <= 1'b1;
                        if (mem_err_i) begin
                            lsu_err_o       <= 1'b1;
                            lsu_err_cause_o <= 2'd2;
                        end else begin
                            lsu_rdata_o <= r_we ? 32'd0 : w_load;
                        end
                    end else if (w_tmo) begin
                        r_state         <= S_IDLE;
                        lsu_done_o      <= 1'b1;
                        lsu_err_o       <= 1'b1;
                        lsu_err_cause_o <= 2'd2;
                    end
                end
                S_ERR: begin
                    r_state         <= S_IDLE;
                    lsu_done_o      <= 1'b1;
                    lsu_err_o       <= 1'b1;
                    lsu_err_cause_o <= r_cause;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
